// File: rtl/clic_gateway_if.sv
// Signal bundle between the interrupt sources/control and the CLIC gateway.
// The gateway side uses the slave modport; stimulus or upstream logic uses master.
interface clic_gateway_if #(
   parameter int N_SOURCE = 32
);
   localparam int IDW = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

   logic [N_SOURCE-1:0] src_i;
   logic [N_SOURCE-1:0] le_i;
   logic [N_SOURCE-1:0] pol_i;
   logic [N_SOURCE-1:0] sw_we_i;
   logic [N_SOURCE-1:0] sw_wdata_i;
   logic                claim_i;
   logic [IDW-1:0]      claim_id_i;
   logic [N_SOURCE-1:0] ip_o;

   modport master (
      output src_i,
      output le_i,
      output pol_i,
      output sw_we_i,
      output sw_wdata_i,
      output claim_i,
      output claim_id_i,
      input  ip_o
   );

   modport slave (
      input  src_i,
      input  le_i,
      input  pol_i,
      input  sw_we_i,
      input  sw_wdata_i,
      input  claim_i,
      input  claim_id_i,
      output ip_o
   );
endinterface

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway producing the registered pending vector for the CLIC adapter.
// Optional macro CLIC_GATEWAY_SYNC_EN inserts a 2-flop synchronizer on every src_i bit.
module clic_gateway #(
   parameter int N_SOURCE = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   clic_gateway_if.slave gw
);
   localparam int IDW = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

   logic [N_SOURCE-1:0] line;
   logic [N_SOURCE-1:0] qual;
   logic [N_SOURCE-1:0] prev;
   logic [N_SOURCE-1:0] edge_det;
   logic [N_SOURCE-1:0] claim_clr;
   logic [N_SOURCE-1:0] ip;
   logic [N_SOURCE-1:0] ip_nxt;

`ifdef CLIC_GATEWAY_SYNC_EN
   logic [N_SOURCE-1:0] sync_meta;
   logic [N_SOURCE-1:0] sync_out;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= gw.src_i;
         sync_out  <= sync_meta;
      end
   end

   assign line = sync_out;
`else
   assign line = gw.src_i;
`endif

   assign qual     = line ^ gw.pol_i;
   assign edge_det = qual & ~prev;

   // Ids at or above N_SOURCE match no index and so clear nothing.
   always_comb begin
      claim_clr = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         claim_clr[i] = gw.claim_i && (gw.claim_id_i == IDW'(i));
      end
   end

   // A fresh edge outranks software writes and claims so no edge is ever dropped.
   always_comb begin
      ip_nxt = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         if (!gw.le_i[i]) begin
            ip_nxt[i] = qual[i];
         end else if (edge_det[i]) begin
            ip_nxt[i] = 1'b1;
         end else if (gw.sw_we_i[i]) begin
            ip_nxt[i] = gw.sw_wdata_i[i];
         end else begin
            ip_nxt[i] = ip[i] & ~claim_clr[i];
         end
      end
   end

   // prev tracks the qualified line in both modes so a mode switch sees current history.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev <= '0;
         ip   <= '0;
      end else begin
         prev <= qual;
         ip   <= ip_nxt;
      end
   end

   assign gw.ip_o = ip;
endmodule

// File: tb/tb_clic_gateway.sv
// Randomized scoreboard bench for clic_gateway (non-power-of-2 source count).
module tb_clic_gateway;
   localparam int N   = 20;
   localparam int IDW = (N > 1) ? $clog2(N) : 1;
`ifdef CLIC_GATEWAY_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk;
   logic rst;

   clic_gateway_if #(.N_SOURCE(N)) gw_if ();

   clic_gateway #(.N_SOURCE(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .gw    (gw_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   r_src, r_le, r_pol, r_we, r_wd;
   logic           r_rst, r_claim;
   logic [IDW-1:0] r_cid;

   logic [N-1:0] m_ip, m_prev;
   logic [N-1:0] m_pipe[$];
   logic [N-1:0] exp_q[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference: pending state after the next clock edge, straight from the gateway rules.
   task automatic model_step();
      logic [N-1:0] s, q, nip;
      bit e, c;
      s = (LAT > 0) ? m_pipe[0] : r_src;
      q = s ^ r_pol;
      if (r_rst) begin
         m_ip   = '0;
         m_prev = '0;
         m_pipe = {'0, '0};
      end else begin
         nip = '0;
         for (int i = 0; i < N; i++) begin
            e = q[i] && !m_prev[i];
            c = r_claim && (int'(r_cid) == i);
            if (!r_le[i])      nip[i] = q[i];
            else if (e)        nip[i] = 1'b1;
            else if (r_we[i])  nip[i] = r_wd[i];
            else               nip[i] = m_ip[i] && !c;
         end
         m_prev = q;
         m_ip   = nip;
         m_pipe.push_back(r_src);
         void'(m_pipe.pop_front());
      end
      exp_q.push_back(m_ip);
   endtask

   task automatic step();
      @(negedge clk);
      rst              = r_rst;
      gw_if.src_i      = r_src;
      gw_if.le_i       = r_le;
      gw_if.pol_i      = r_pol;
      gw_if.sw_we_i    = r_we;
      gw_if.sw_wdata_i = r_wd;
      gw_if.claim_i    = r_claim;
      gw_if.claim_id_i = r_cid;
      model_step();
   endtask

   initial begin
      logic [N-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (gw_if.ip_o !== e) begin
               miscompares++;
               $display("FAIL ip_o t=%0t got %h expected %h", $time, gw_if.ip_o, e);
            end
         end
      end
   end

   initial begin
      m_pipe = {'0, '0};
      m_ip = '0; m_prev = '0;
      r_rst = 1'b1; r_src = '1; r_le = '0; r_pol = '0;
      r_we = '0; r_wd = '0; r_claim = 1'b0; r_cid = '0;
      rst = 1'b1;
      gw_if.src_i = '0; gw_if.le_i = '0; gw_if.pol_i = '0;
      gw_if.sw_we_i = '0; gw_if.sw_wdata_i = '0;
      gw_if.claim_i = 1'b0; gw_if.claim_id_i = '0;

      // reset held with all lines high, then release in level mode
      repeat (3) step();
      r_rst = 1'b0;
      repeat (4) step();

      // level, active-low on source 3, claim has no effect
      r_pol[3] = 1'b1; r_src[3] = 1'b0;
      repeat (3) step();
      r_src[3] = 1'b1;
      repeat (3) step();
      r_src[3] = 1'b0;
      repeat (3) step();
      r_claim = 1'b1; r_cid = IDW'(3);
      step();
      r_claim = 1'b0;
      repeat (2) step();

      // edge set / hold / claim on source 5
      r_src = '0; r_pol = '0;
      repeat (4) step();
      r_le[5] = 1'b1;
      step();
      r_src[5] = 1'b1; step();
      r_src[5] = 1'b0; repeat (5) step();
      r_claim = 1'b1; r_cid = IDW'(5); step();
      r_claim = 1'b0; repeat (3) step();
      r_src[5] = 1'b1; repeat (5) step();
      r_claim = 1'b1; r_cid = IDW'(5); step();
      r_claim = 1'b0; repeat (5) step();
      r_src[5] = 1'b0; repeat (3) step();
      r_src[5] = 1'b1; repeat (5) step();

      // simultaneous edge, claim and software clear on source 7
      r_le[7] = 1'b1;
      repeat (3) step();
      r_src[7] = 1'b1;
      repeat (LAT) step();
      r_claim = 1'b1; r_cid = IDW'(7); r_we[7] = 1'b1; r_wd[7] = 1'b0;
      step();
      r_claim = 1'b0;
      step();
      r_we[7] = 1'b0;
      repeat (3) step();

      // software pend on source 0, then out-of-range claims
      r_le[0] = 1'b1;
      step();
      r_we[0] = 1'b1; r_wd[0] = 1'b1; step();
      r_we[0] = 1'b0;
      r_claim = 1'b1; r_cid = IDW'(N); step();
      r_cid = '1; step();
      r_claim = 1'b0; repeat (2) step();

      // mode switch on a held line must not fabricate an edge
      r_le[2] = 1'b0; r_src[2] = 1'b1;
      repeat (4) step();
      r_we[2] = 1'b1; r_wd[2] = 1'b0; r_le[2] = 1'b1;
      step();
      r_we[2] = 1'b0;
      repeat (4) step();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r_rst   = ($urandom_range(0, 249) == 0);
         r_src   = r_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
         if ($urandom_range(0, 39) == 0) r_le  = N'($urandom);
         if ($urandom_range(0, 59) == 0) r_pol = N'($urandom);
         r_we    = N'($urandom) & N'($urandom) & N'($urandom);
         r_wd    = N'($urandom);
         r_claim = ($urandom_range(0, 2) == 0);
         r_cid   = IDW'($urandom_range(0, (1 << IDW) - 1));
         step();
      end

      r_rst = 1'b0; r_we = '0; r_claim = 1'b0;
      repeat (2) step();
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
